acc_writeback: RTL and testbench
================================

// Module: acc_writeback
// PURPOSE
//  Writeback stage directly downstream of the combinational ALU. Holds the architectural
//  accumulator, the carry register and the zero/parity flags; acc and carry feed the ALU's
//  accumulator and carry inputs on the next cycle. Also owns the push/pop operand stack,
//  the load-return handshake and the program-done (acknowledge) flag.
// PARAMETERS
//  W            8   datapath width (acc, ALU result, stack entries, memory data)
//  STACK_DEPTH  8   operand-stack entries; power of two, >= 2
// PORTS
//  clk          in   1         rising-edge clock; the block's only clock
//  reset        in   1         asynchronous, active-high; clears all state
//  wb_valid     in   1         ALU command/result valid this cycle; acted on only when ~busy
//  alu_cmd      in   4         opcode of the instruction whose result is presented
//  alu_result   in   W         ALU result
//  alu_cout     in   1         ALU carry/shift-out
//  mem_rvalid   in   1         load data valid (single-cycle pulse)
//  mem_rdata    in   W         load data
//  acc          out  W         accumulator register, to ALU accumulator input
//  carry        out  1         carry register, to ALU carry input
//  flag_zero    out  1         1 when last written acc value == 0
//  flag_pari    out  1         XOR-reduction of last written acc value
//  busy         out  1         1 while waiting on load data; upstream holds its instruction
//  stack_empty  out  1         stack count == 0
//  stack_full   out  1         stack count == STACK_DEPTH
//  stack_err    out  1         sticky: overflow or underflow has occurred
//  done         out  1         sticky: acknowledge command has retired
// BEHAVIOUR
//  Reset: acc=0, carry=0, flag_zero=1, flag_pari=0, busy=0, stack count=0 (empty=1, full=0),
//   stack_err=0, done=0, FSM=IDLE. Reset asserted mid-load aborts the load and returns to IDLE.
//  Commit: "commit v" = acc<=v, flag_zero<=(v==0), flag_pari<=^v, all on the same clock edge.
//   Flags are always computed inside this block from v; ALU flag outputs are not used.
//  IDLE, wb_valid=1, by alu_cmd (effects visible one cycle after the edge):
//   0000 shift        commit alu_result; carry<=alu_cout
//   0001-0011 branch  no state change; flags hold for branch resolution
//   0100 load         no commit; FSM->WAIT_LD; busy=1 from the next cycle
//   0101 store        no state change
//   0110 push         push alu_result; acc/flags/carry unchanged; if full: no write, stack_err<=1
//   0111 pop          commit top entry, count-1; if empty: acc/flags unchanged, stack_err<=1
//   1000-1011 logic   commit alu_result; carry unchanged
//   1100/1101 add/sub commit alu_result; carry<=alu_cout
//   1110              no-op
//   1111 ack          done<=1 (sticky until reset); no other state change
//  WAIT_LD: busy=1; wb_valid ignored; on mem_rvalid: commit mem_rdata, carry unchanged, FSM->IDLE,
//   busy=0 on the next cycle. Throughput: one command per cycle when not busy; load >= 2 cycles.
//  mem_rvalid in IDLE is ignored. Pop latency: top entry lands in acc on the same edge as count-1.
//  Stack: LIFO, pointer-indexed array; no wrap: full/empty guards block the pointer. Push and
//   pop cannot coincide (one command per cycle). stack_err never clears except via reset.
//  All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//  Shared package isa_pkg: alu_cmd_e enum (the 16 opcodes above), W default, wb_state_e {IDLE, WAIT_LD}.
//  Sub-module wb_stack (#(W, STACK_DEPTH)): push/pop/din -> top, empty, full, err_pulse;
//   acc_writeback holds the FSM, acc/carry/flag registers and sticky bits.
// TESTING
//  1 reset mid-WAIT_LD -> acc=0, flag_zero=1, busy=0 next cycle; a later mem_rvalid is ignored.
//  2 add alu_result=8'h00 alu_cout=1 -> acc=0, carry=1, flag_zero=1, flag_pari=0; then XOR
//    alu_result=8'h07 -> acc=07, carry stays 1, zero=0, pari=1.
//  3 push 8 values 8'h01..8'h08 -> full=1; 9th push -> stack_err=1, contents intact;
//    8 pops -> acc sequence 08..01, empty=1.
//  4 pop on empty with acc=8'h5A -> acc stays 5A, stack_err=1 sticky across later valid ops.
//  5 load, mem_rvalid after 3 cycles with 8'hC3 -> busy high 3 cycles, an and-command presented
//    during busy is dropped, acc=C3, pari=0, zero=0, busy=0.
//  6 ack (1111) -> done=1, acc/carry/flags unchanged; done stays 1 through following commands.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the writeback stage: opcodes, FSM states, default width.
package isa_pkg;

    localparam int unsigned W_DEFAULT = 8;

    typedef enum logic [3:0] {
        CMD_SHIFT = 4'h0,
        CMD_BR0   = 4'h1,
        CMD_BR1   = 4'h2,
        CMD_BR2   = 4'h3,
        CMD_LOAD  = 4'h4,
        CMD_STORE = 4'h5,
        CMD_PUSH  = 4'h6,
        CMD_POP   = 4'h7,
        CMD_AND   = 4'h8,
        CMD_OR    = 4'h9,
        CMD_XOR   = 4'hA,
        CMD_NOT   = 4'hB,
        CMD_ADD   = 4'hC,
        CMD_SUB   = 4'hD,
        CMD_NOP   = 4'hE,
        CMD_ACK   = 4'hF
    } alu_cmd_e;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stack.sv
// LIFO operand stack: pointer-indexed array with full/empty guards, no wrap.
module wb_stack #(
    parameter int unsigned W           = 8,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         err_pulse
);

    localparam int unsigned PtrW = $clog2(STACK_DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(STACK_DEPTH);

    logic [W-1:0]    mem_q [STACK_DEPTH];
    logic [PtrW:0]   count_q, count_d;
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    // Count == DEPTH has zero low bits, so the write pointer is only used when not full.
    assign wr_ptr    = count_q[PtrW-1:0];
    assign rd_ptr    = count_q[PtrW-1:0] - PtrW'(1);
    assign empty     = (count_q == '0);
    assign full      = (count_q == FullCnt);
    assign top       = mem_q[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign err_pulse = (push && full) || (pop && empty);

    // Next count: guarded increment/decrement.
    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + 1'b1;
        end else if (do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/acc_writeback.sv
// Writeback stage: accumulator, carry, zero/parity flags, load handshake, stack and done flag.
module acc_writeback
    import isa_pkg::*;
#(
    parameter int unsigned W           = W_DEFAULT,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wb_valid,
    input  logic [3:0]   alu_cmd,
    input  logic [W-1:0] alu_result,
    input  logic         alu_cout,
    input  logic         mem_rvalid,
    input  logic [W-1:0] mem_rdata,
    output logic [W-1:0] acc,
    output logic         carry,
    output logic         flag_zero,
    output logic         flag_pari,
    output logic         busy,
    output logic         stack_empty,
    output logic         stack_full,
    output logic         stack_err,
    output logic         done
);

    wb_state_e    state_q, state_d;
    alu_cmd_e     cmd;
    logic [W-1:0] acc_q, acc_d, commit_val, stack_top;
    logic         carry_q, carry_d, zero_q, zero_d, pari_q, pari_d;
    logic         err_q, err_d, done_q, done_d;
    logic         commit_en, push, pop, err_pulse;

    assign cmd = alu_cmd_e'(alu_cmd);

    wb_stack #(
        .W          (W),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .din      (alu_result),
        .top      (stack_top),
        .empty    (stack_empty),
        .full     (stack_full),
        .err_pulse(err_pulse)
    );

    // Next-state: command decode in IDLE, load return in WAIT_LD, shared commit path.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        pari_d     = pari_q;
        done_d     = done_q;
        commit_en  = 1'b0;
        commit_val = alu_result;
        push       = 1'b0;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    case (cmd)
                        CMD_SHIFT, CMD_ADD, CMD_SUB: begin
                            commit_en = 1'b1;
                            carry_d   = alu_cout;
                        end
                        CMD_AND, CMD_OR, CMD_XOR, CMD_NOT: begin
                            commit_en = 1'b1;
                        end
                        CMD_LOAD: state_d = WAIT_LD;
                        CMD_PUSH: push = 1'b1;
                        CMD_POP: begin
                            pop = 1'b1;
                            if (!stack_empty) begin
                                commit_en  = 1'b1;
                                commit_val = stack_top;
                            end
                        end
                        CMD_ACK: done_d = 1'b1;
                        default: ;  // branches, store, no-op: flags hold
                    endcase
                end
            end
            WAIT_LD: begin
                if (mem_rvalid) begin
                    commit_en  = 1'b1;
                    commit_val = mem_rdata;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit_en) begin
            acc_d  = commit_val;
            zero_d = (commit_val == '0);
            pari_d = ^commit_val;
        end

        err_d = err_q | err_pulse;
    end

    // Architectural state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            pari_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            pari_q  <= pari_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign acc       = acc_q;
    assign carry     = carry_q;
    assign flag_zero = zero_q;
    assign flag_pari = pari_q;
    assign busy      = (state_q == WAIT_LD);
    assign stack_err = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_acc_writeback.sv
// Self-checking bench for acc_writeback: vector table through a scoreboard queue, plus
// hand-written reset-mid-load and empty-pop sequences.
module tb_acc_writeback;

    logic       clk = 1'b0;
    logic       reset;
    logic       wb_valid;
    logic [3:0] alu_cmd;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic       mem_rvalid;
    logic [7:0] mem_rdata;
    logic [7:0] acc;
    logic       carry, flag_zero, flag_pari, busy;
    logic       stack_empty, stack_full, stack_err, done;

    int tests = 0;
    int fails = 0;

    acc_writeback #(
        .W          (8),
        .STACK_DEPTH(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .acc        (acc),
        .carry      (carry),
        .flag_zero  (flag_zero),
        .flag_pari  (flag_pari),
        .busy       (busy),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .stack_err  (stack_err),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  cmd;
        logic [7:0]  res;
        logic        cout;
        logic        rv;
        logic [7:0]  rdata;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb[$];

    // Observed outputs packed as {acc, carry, zero, pari, busy, empty, full, err, done}.
    function automatic logic [15:0] ex(input logic [7:0] a, input logic c, input logic z,
                                       input logic p, input logic b, input logic e,
                                       input logic f, input logic er, input logic d);
        return {a, c, z, p, b, e, f, er, d};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [3:0] cm, input logic [7:0] r,
                                 input logic co, input logic rv, input logic [7:0] rd,
                                 input logic [15:0] e);
        vec_t t;
        t.valid = v; t.cmd = cm; t.res = r; t.cout = co; t.rv = rv; t.rdata = rd; t.exp = e;
        return t;
    endfunction

    function automatic logic [15:0] observed();
        return {acc, carry, flag_zero, flag_pari, busy, stack_empty, stack_full, stack_err,
                done};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got acc=%h c/z/p/b/e/f/err/d=%b required acc=%h c/z/p/b/e/f/err/d=%b",
                     name, got[15:8], got[7:0], want[15:8], want[7:0]);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] cm, input logic [7:0] r,
                         input logic co, input logic rv, input logic [7:0] rd);
        wb_valid = v; alu_cmd = cm; alu_result = r; alu_cout = co;
        mem_rvalid = rv; mem_rdata = rd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 4'hE, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        logic [15:0] want;

        // ---- vector table ----
        // add 00 cout1 -> zero, carry set
        tbl.push_back(mkv(1, 4'hC, 8'h00, 1, 0, 8'h00, ex(8'h00, 1, 1, 0, 0, 1, 0, 0, 0)));
        // xor 07: carry holds
        tbl.push_back(mkv(1, 4'hA, 8'h07, 0, 0, 8'h00, ex(8'h07, 1, 0, 1, 0, 1, 0, 0, 0)));
        for (int i = 1; i <= 8; i++) begin
            v = i[7:0];
            tbl.push_back(mkv(1, 4'h6, v, 0, 0, 8'h00,
                              ex(8'h07, 1, 0, 1, 0, 0, (i == 8), 0, 0)));
        end
        // overflow push
        tbl.push_back(mkv(1, 4'h6, 8'h09, 0, 0, 8'h00, ex(8'h07, 1, 0, 1, 0, 0, 1, 1, 0)));
        for (int i = 0; i < 8; i++) begin
            v = 8'(8 - i);
            tbl.push_back(mkv(1, 4'h7, 8'hEE, 0, 0, 8'h00,
                              ex(v, 1, 0, ^v, 0, (i == 7), 0, 1, 0)));
        end
        // shift 5A cout0
        tbl.push_back(mkv(1, 4'h0, 8'h5A, 0, 0, 8'h00, ex(8'h5A, 0, 0, 0, 0, 1, 0, 1, 0)));
        // pop on empty: acc holds
        tbl.push_back(mkv(1, 4'h7, 8'h00, 1, 0, 8'h00, ex(8'h5A, 0, 0, 0, 0, 1, 0, 1, 0)));
        // ack: done only
        tbl.push_back(mkv(1, 4'hF, 8'hFF, 1, 0, 8'h00, ex(8'h5A, 0, 0, 0, 0, 1, 0, 1, 1)));
        // sub 00 cout1
        tbl.push_back(mkv(1, 4'hD, 8'h00, 1, 0, 8'h00, ex(8'h00, 1, 1, 0, 0, 1, 0, 1, 1)));
        // branch, store, no-op, invalid add, rvalid in IDLE: all hold
        tbl.push_back(mkv(1, 4'h2, 8'h33, 0, 0, 8'h00, ex(8'h00, 1, 1, 0, 0, 1, 0, 1, 1)));
        tbl.push_back(mkv(1, 4'h5, 8'h44, 0, 0, 8'h00, ex(8'h00, 1, 1, 0, 0, 1, 0, 1, 1)));
        tbl.push_back(mkv(1, 4'hE, 8'h55, 0, 0, 8'h00, ex(8'h00, 1, 1, 0, 0, 1, 0, 1, 1)));
        tbl.push_back(mkv(0, 4'hC, 8'h11, 0, 0, 8'h00, ex(8'h00, 1, 1, 0, 0, 1, 0, 1, 1)));
        tbl.push_back(mkv(0, 4'hE, 8'h00, 0, 1, 8'h99, ex(8'h00, 1, 1, 0, 0, 1, 0, 1, 1)));
        // and F0 cout0: carry holds
        tbl.push_back(mkv(1, 4'h8, 8'hF0, 0, 0, 8'h00, ex(8'hF0, 1, 0, 0, 0, 1, 0, 1, 1)));
        // load, two dropped and-commands while busy, then data C3
        tbl.push_back(mkv(1, 4'h4, 8'h00, 0, 0, 8'h00, ex(8'hF0, 1, 0, 0, 1, 1, 0, 1, 1)));
        tbl.push_back(mkv(1, 4'h8, 8'h11, 0, 0, 8'h00, ex(8'hF0, 1, 0, 0, 1, 1, 0, 1, 1)));
        tbl.push_back(mkv(1, 4'h8, 8'h12, 0, 0, 8'h00, ex(8'hF0, 1, 0, 0, 1, 1, 0, 1, 1)));
        tbl.push_back(mkv(1, 4'h8, 8'h13, 0, 1, 8'hC3, ex(8'hC3, 1, 0, 0, 0, 1, 0, 1, 1)));
        // done stays set after further commands
        tbl.push_back(mkv(1, 4'h9, 8'h80, 0, 0, 8'h00, ex(8'h80, 1, 0, 1, 0, 1, 0, 1, 1)));

        do_reset();
        check("reset_state", observed(), ex(8'h00, 0, 1, 0, 0, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].cmd, tbl[i].res, tbl[i].cout, tbl[i].rv, tbl[i].rdata);
            sb.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            want = sb.pop_front();
            check($sformatf("vec%0d", i), observed(), want);
        end
        idle_inputs();

        // ---- reset in the middle of a load ----
        do_reset();
        drive(1, 4'h0, 8'h5A, 1, 0, 8'h00);
        @(posedge clk); #1;
        drive(1, 4'h4, 8'h00, 0, 0, 8'h00);
        @(posedge clk); #1;
        idle_inputs();
        check("load_busy", observed(), ex(8'h5A, 1, 0, 0, 1, 1, 0, 0, 0));
        reset = 1'b1;
        #2;
        check("reset_async", observed(), ex(8'h00, 0, 1, 0, 0, 1, 0, 0, 0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_load", observed(), ex(8'h00, 0, 1, 0, 0, 1, 0, 0, 0));
        drive(0, 4'hE, 8'h00, 0, 1, 8'h77);
        @(posedge clk); #1;
        idle_inputs();
        check("late_rvalid_ignored", observed(), ex(8'h00, 0, 1, 0, 0, 1, 0, 0, 0));

        // ---- pop on empty from a fresh reset; error sticks ----
        do_reset();
        drive(1, 4'h9, 8'h5A, 0, 0, 8'h00);
        @(posedge clk); #1;
        drive(1, 4'h7, 8'h00, 0, 0, 8'h00);
        @(posedge clk); #1;
        check("pop_empty", observed(), ex(8'h5A, 0, 0, 0, 0, 1, 0, 1, 0));
        drive(1, 4'h6, 8'h3C, 0, 0, 8'h00);
        @(posedge clk); #1;
        check("err_sticky_push", observed(), ex(8'h5A, 0, 0, 0, 0, 0, 0, 1, 0));
        drive(1, 4'h7, 8'h00, 0, 0, 8'h00);
        @(posedge clk); #1;
        idle_inputs();
        check("err_sticky_pop", observed(), ex(8'h3C, 0, 0, 0, 0, 1, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
